// File: rtl/soc_or1k_wb_pkg.sv
// Shared types for the soc_or1k_wb subsystem: arbiter state, Wishbone CTI codes
// and the bundled master request carried through the arbiter mux.
package soc_or1k_wb_pkg;

    localparam int WB_AW = 32;
    localparam int WB_DW = 32;
    localparam int WB_SW = WB_DW / 8;

    // One-hot encoding so the state register doubles as the grant vector.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        GNT0 = 2'b01,
        GNT1 = 2'b10
    } arb_state_e;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    typedef struct packed {
        logic             cyc;
        logic             stb;
        logic             we;
        logic [WB_AW-1:0] adr;
        logic [WB_DW-1:0] dat;
        logic [WB_SW-1:0] sel;
        logic [2:0]       cti;
        logic [1:0]       bte;
    } wb_req_t;

endpackage

// File: rtl/soc_or1k_wb_arb_watchdog.sv
// Stall watchdog: counts strobe cycles without a slave termination and flags a
// timeout on the cycle the count reaches TIMEOUT-1.
module soc_or1k_wb_arb_watchdog #(
    parameter int TIMEOUT = 1024
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_stb,
    input  logic i_term,
    input  logic i_clear,
    output logic o_timeout
);

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    logic [CW-1:0] r_count;

    assign o_timeout = i_stb && (r_count == CW'(TIMEOUT - 1));

    // The count restarts after every timeout so a master that keeps cyc high
    // gets a fresh window rather than a stuck error.
    always_ff @(posedge i_clk) begin
        if (i_rst || !i_stb || i_term || i_clear || o_timeout) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule

// File: rtl/soc_or1k_wb_arbiter.sv
// Two-master round-robin Wishbone B3 arbiter holding ownership for a whole cyc.
// Optional stall watchdog enabled by defining SOC_OR1K_WB_ARB_TIMEOUT_EN.
module soc_or1k_wb_arbiter
    import soc_or1k_wb_pkg::*;
#(
    parameter int AW      = WB_AW,
    parameter int DW      = WB_DW,
    parameter int TIMEOUT = 1024
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_i,
    input  logic            m0_cyc_i,
    input  logic            m0_stb_i,
    input  logic            m0_we_i,
    input  logic [AW-1:0]   m0_adr_i,
    input  logic [DW-1:0]   m0_dat_i,
    input  logic [DW/8-1:0] m0_sel_i,
    input  logic [2:0]      m0_cti_i,
    input  logic [1:0]      m0_bte_i,
    output logic [DW-1:0]   m0_dat_o,
    output logic            m0_ack_o,
    output logic            m0_err_o,
    output logic            m0_rty_o,
    input  logic            m1_cyc_i,
    input  logic            m1_stb_i,
    input  logic            m1_we_i,
    input  logic [AW-1:0]   m1_adr_i,
    input  logic [DW-1:0]   m1_dat_i,
    input  logic [DW/8-1:0] m1_sel_i,
    input  logic [2:0]      m1_cti_i,
    input  logic [1:0]      m1_bte_i,
    output logic [DW-1:0]   m1_dat_o,
    output logic            m1_ack_o,
    output logic            m1_err_o,
    output logic            m1_rty_o,
    output logic            s_cyc_o,
    output logic            s_stb_o,
    output logic            s_we_o,
    output logic [AW-1:0]   s_adr_o,
    output logic [DW-1:0]   s_dat_o,
    output logic [DW/8-1:0] s_sel_o,
    output logic [2:0]      s_cti_o,
    output logic [1:0]      s_bte_o,
    input  logic [DW-1:0]   s_dat_i,
    input  logic            s_ack_i,
    input  logic            s_err_i,
    input  logic            s_rty_i,
    output logic [1:0]      grant_o
);

    arb_state_e r_state, w_next;
    logic       r_last, w_last_next;   // previous owner: 0 = m0, 1 = m1
    wb_req_t    w_m0_req, w_m1_req, w_req;
    logic       w_own0, w_own1, w_timeout;

    // Requests are packed at the subsystem bus width and cast back out.
    assign w_m0_req = '{cyc: m0_cyc_i, stb: m0_stb_i, we: m0_we_i,
                        adr: WB_AW'(m0_adr_i), dat: WB_DW'(m0_dat_i),
                        sel: WB_SW'(m0_sel_i), cti: m0_cti_i, bte: m0_bte_i};
    assign w_m1_req = '{cyc: m1_cyc_i, stb: m1_stb_i, we: m1_we_i,
                        adr: WB_AW'(m1_adr_i), dat: WB_DW'(m1_dat_i),
                        sel: WB_SW'(m1_sel_i), cti: m1_cti_i, bte: m1_bte_i};

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state <= IDLE;
            r_last  <= 1'b1;
        end else begin
            r_state <= w_next;
            r_last  <= w_last_next;
        end
    end

    // Release and the other master's request resolve in one step: no idle gap.
    always_comb begin
        w_next      = r_state;
        w_last_next = r_last;
        case (r_state)
            IDLE: begin
                if (m0_cyc_i && m1_cyc_i) w_next = r_last ? GNT0 : GNT1;
                else if (m0_cyc_i)        w_next = GNT0;
                else if (m1_cyc_i)        w_next = GNT1;
            end
            GNT0: begin
                if (!m0_cyc_i) begin
                    w_last_next = 1'b0;
                    w_next      = m1_cyc_i ? GNT1 : IDLE;
                end
            end
            GNT1: begin
                if (!m1_cyc_i) begin
                    w_last_next = 1'b1;
                    w_next      = m0_cyc_i ? GNT0 : IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        w_req  = '0;
        w_own0 = 1'b0;
        w_own1 = 1'b0;
        case (r_state)
            GNT0: begin
                w_req  = w_m0_req;
                w_own0 = 1'b1;
            end
            GNT1: begin
                w_req  = w_m1_req;
                w_own1 = 1'b1;
            end
            default: ;
        endcase
    end

    assign grant_o  = r_state;

    assign s_cyc_o  = w_req.cyc & ~w_timeout;
    assign s_stb_o  = w_req.stb & ~w_timeout;
    assign s_we_o   = w_req.we;
    assign s_adr_o  = AW'(w_req.adr);
    assign s_dat_o  = DW'(w_req.dat);
    assign s_sel_o  = (DW/8)'(w_req.sel);
    assign s_cti_o  = w_req.cti;
    assign s_bte_o  = w_req.bte;

    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;
    assign m0_ack_o = w_own0 & s_ack_i;
    assign m1_ack_o = w_own1 & s_ack_i;
    assign m0_err_o = w_own0 & (s_err_i | w_timeout);
    assign m1_err_o = w_own1 & (s_err_i | w_timeout);
    assign m0_rty_o = w_own0 & s_rty_i;
    assign m1_rty_o = w_own1 & s_rty_i;

`ifdef SOC_OR1K_WB_ARB_TIMEOUT_EN
    soc_or1k_wb_arb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .i_clk     (wb_clk_i),
        .i_rst     (wb_rst_i),
        .i_stb     (w_req.stb),
        .i_term    (s_ack_i | s_err_i | s_rty_i),
        .i_clear   (w_next != r_state),
        .o_timeout (w_timeout)
    );
`else
    logic w_unused_cfg;
    assign w_unused_cfg = (TIMEOUT < 2);
    assign w_timeout    = 1'b0;
`endif

endmodule

// File: tb/tb_soc_or1k_wb_arbiter.sv
// Directed bench for soc_or1k_wb_arbiter: stimulus pushes expected terminations
// into a queue, a negedge monitor pops and compares them.
module tb_soc_or1k_wb_arbiter;
    import soc_or1k_wb_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;
`ifdef SOC_OR1K_WB_ARB_TIMEOUT_EN
    localparam int TO = 8;
`else
    localparam int TO = 1024;
`endif

    logic            clk, rst;
    logic            m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
    logic [AW-1:0]   m0_adr, m1_adr, s_adr;
    logic [DW-1:0]   m0_wdat, m1_wdat, m0_rdat, m1_rdat, s_wdat, s_rdat;
    logic [DW/8-1:0] m0_sel, m1_sel, s_sel;
    logic [2:0]      m0_cti, m1_cti, s_cti;
    logic [1:0]      m0_bte, m1_bte, s_bte, grant;
    logic            m0_ack, m0_err, m0_rty, m1_ack, m1_err, m1_rty;
    logic            s_cyc, s_stb, s_we, s_ack, s_err, s_rty;

    // {owner is m1, error, read data (0 for errors)}
    logic [33:0] exp_q[$];
    int          checks = 0;
    int          errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    soc_or1k_wb_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
        .wb_clk_i (clk),    .wb_rst_i (rst),
        .m0_cyc_i (m0_cyc), .m0_stb_i (m0_stb), .m0_we_i (m0_we),
        .m0_adr_i (m0_adr), .m0_dat_i (m0_wdat), .m0_sel_i (m0_sel),
        .m0_cti_i (m0_cti), .m0_bte_i (m0_bte), .m0_dat_o (m0_rdat),
        .m0_ack_o (m0_ack), .m0_err_o (m0_err), .m0_rty_o (m0_rty),
        .m1_cyc_i (m1_cyc), .m1_stb_i (m1_stb), .m1_we_i (m1_we),
        .m1_adr_i (m1_adr), .m1_dat_i (m1_wdat), .m1_sel_i (m1_sel),
        .m1_cti_i (m1_cti), .m1_bte_i (m1_bte), .m1_dat_o (m1_rdat),
        .m1_ack_o (m1_ack), .m1_err_o (m1_err), .m1_rty_o (m1_rty),
        .s_cyc_o  (s_cyc),  .s_stb_o  (s_stb),  .s_we_o   (s_we),
        .s_adr_o  (s_adr),  .s_dat_o  (s_wdat), .s_sel_o  (s_sel),
        .s_cti_o  (s_cti),  .s_bte_o  (s_bte),  .s_dat_i  (s_rdat),
        .s_ack_i  (s_ack),  .s_err_i  (s_err),  .s_rty_i  (s_rty),
        .grant_o  (grant)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic req_m0(input logic c, input logic [AW-1:0] a, input logic [2:0] cti);
        m0_cyc = c; m0_stb = c; m0_adr = a; m0_cti = cti;
    endtask

    task automatic req_m1(input logic c, input logic [AW-1:0] a, input logic [2:0] cti);
        m1_cyc = c; m1_stb = c; m1_adr = a; m1_cti = cti;
    endtask

    task automatic slave_ack(input logic [DW-1:0] d, input logic to_m1);
        s_ack  = 1'b1;
        s_rdat = d;
        exp_q.push_back({to_m1, 1'b0, d});
    endtask

    always @(negedge clk) begin : monitor
        logic [33:0] act;
        logic [33:0] exp;
        logic        t0, t1;
        t0 = m0_ack | m0_err;
        t1 = m1_ack | m1_err;
        if (t0 || t1) begin
            act = {t1, m0_err | m1_err, (m0_err | m1_err) ? 32'h0 : (t1 ? m1_rdat : m0_rdat)};
            if (t0 && t1) chk("both_masters_terminated", {t0, t1}, 2'b10);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_term: got %0h expected none", act);
            end else begin
                exp = exp_q.pop_front();
                chk("term", act, exp);
            end
        end
    end

    initial begin
        rst = 1'b1;
        m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_adr = '0; m0_wdat = '0; m0_sel = '0; m0_cti = '0; m0_bte = '0;
        m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_adr = '0; m1_wdat = '0; m1_sel = '0; m1_cti = '0; m1_bte = '0;
        s_rdat = '0; s_ack = 0; s_err = 0; s_rty = 0;

        // Reset and single request
        repeat (3) tick();
        settle();
        chk("rst_grant", grant, 2'b00);
        chk("rst_s_cyc", s_cyc, 0);
        chk("rst_s_stb", s_stb, 0);
        chk("rst_terms", {m0_ack, m0_err, m0_rty, m1_ack, m1_err, m1_rty}, 0);
        rst = 1'b0;
        req_m0(1, 32'h100, CTI_CLASSIC);
        settle();
        chk("arb_latency_s_cyc", s_cyc, 0);
        tick(); settle();
        chk("single_grant", grant, 2'b01);
        chk("single_s_cyc", s_cyc, 1);
        chk("single_s_adr", s_adr, 32'h100);
        chk("single_s_we", s_we, 0);
        slave_ack(32'hDEADBEEF, 0);
        settle();
        chk("single_m0_ack", m0_ack, 1);
        chk("single_m1_ack", m1_ack, 0);
        chk("single_m0_dat", m0_rdat, 32'hDEADBEEF);
        tick();
        s_ack = 0; req_m0(0, 32'h100, CTI_CLASSIC);
        tick();

        // Simultaneous requests after reset
        rst = 1'b1; tick(); rst = 1'b0;
        req_m0(1, 32'h200, CTI_CLASSIC);
        req_m1(1, 32'h300, CTI_CLASSIC);
        m1_we = 1; m1_wdat = 32'hCAFE0001; m1_sel = 4'h5;
        tick(); settle();
        chk("tie_m0_first", grant, 2'b01);
        chk("tie_s_adr", s_adr, 32'h200);
        slave_ack(32'h11111111, 0);
        tick();
        s_ack = 0; req_m0(0, 32'h200, CTI_CLASSIC);
        tick(); settle();
        chk("handoff_no_idle", grant, 2'b10);
        chk("handoff_s_adr", s_adr, 32'h300);
        chk("handoff_s_we", s_we, 1);
        chk("handoff_s_dat", s_wdat, 32'hCAFE0001);
        chk("handoff_s_sel", s_sel, 4'h5);
        slave_ack(32'h22222222, 1);
        settle();
        chk("non_owner_ack", m0_ack, 0);
        tick();
        s_ack = 0; req_m1(0, 32'h300, CTI_CLASSIC); m1_we = 0;
        tick();

        // Burst hold: m1 owns a 4-beat incrementing burst while m0 waits
        req_m1(1, 32'h400, CTI_INCR);
        tick(); settle();
        chk("burst_grant", grant, 2'b10);
        req_m0(1, 32'h500, CTI_CLASSIC);
        for (int k = 0; k < 4; k++) begin
            m1_adr = 32'h400 + 32'(4 * k);
            m1_cti = (k == 3) ? CTI_EOB : CTI_INCR;
            slave_ack(32'hB0000000 + 32'(k), 1);
            settle();
            chk("burst_hold", grant, 2'b10);
            chk("burst_cti", s_cti, (k == 3) ? CTI_EOB : CTI_INCR);
            chk("burst_adr", s_adr, 32'h400 + 32'(4 * k));
            tick();
        end
        s_ack = 0; req_m1(0, 32'h40C, CTI_CLASSIC);
        settle();
        chk("burst_release_cycle", grant, 2'b10);
        tick(); settle();
        chk("burst_handoff_m0", grant, 2'b01);
        slave_ack(32'h33333333, 0);
        tick();
        s_ack = 0; req_m0(0, 32'h500, CTI_CLASSIC);
        tick();

        // Round-robin with both masters re-requesting continuously
        rst = 1'b1; tick(); rst = 1'b0;
        req_m0(1, 32'h800, CTI_CLASSIC);
        req_m1(1, 32'h900, CTI_CLASSIC);
        tick();
        for (int k = 0; k < 4; k++) begin
            logic to_m1;
            to_m1 = (k % 2) == 1;
            settle();
            chk("rr_grant", grant, to_m1 ? 2'b10 : 2'b01);
            slave_ack(32'hA0000000 + 32'(k), to_m1);
            tick();
            s_ack = 0;
            if (to_m1) req_m1(0, 32'h900, CTI_CLASSIC);
            else       req_m0(0, 32'h800, CTI_CLASSIC);
            tick();
            if (to_m1) req_m1(1, 32'h900, CTI_CLASSIC);
            else       req_m0(1, 32'h800, CTI_CLASSIC);
        end
        req_m0(0, 32'h800, CTI_CLASSIC);
        req_m1(0, 32'h900, CTI_CLASSIC);
        tick(); tick();

        // Reset asserted during m0's second burst beat
        req_m0(1, 32'h600, CTI_INCR);
        tick(); settle();
        chk("rstmid_grant_before", grant, 2'b01);
        slave_ack(32'h44444444, 0);
        tick();
        s_ack = 0; m0_adr = 32'h604;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        s_ack = 1; s_rdat = 32'h55555555;
        settle();
        chk("rstmid_grant", grant, 2'b00);
        chk("rstmid_s_cyc", s_cyc, 0);
        chk("rstmid_s_stb", s_stb, 0);
        chk("rstmid_terms", {m0_ack, m0_err, m0_rty, m1_ack, m1_err, m1_rty}, 0);
        @(negedge clk); #1;
        s_ack = 0; req_m0(0, 32'h604, CTI_CLASSIC);
        tick(); tick();

`ifdef SOC_OR1K_WB_ARB_TIMEOUT_EN
        // Slave never terminates: watchdog errors on the eighth strobe cycle
        begin
            int err_at;
            err_at = -1;
            req_m0(1, 32'h700, CTI_CLASSIC);
            tick();
            exp_q.push_back({1'b0, 1'b1, 32'h0});
            for (int c = 0; c < 12; c++) begin
                settle();
                if (m0_err && err_at < 0) begin
                    err_at = c;
                    chk("timeout_stb_forced", s_stb, 0);
                    chk("timeout_cyc_forced", s_cyc, 0);
                    break;
                end
                tick();
            end
            chk("timeout_cycle", err_at, 7);
            tick();
            req_m0(0, 32'h700, CTI_CLASSIC);
            tick(); tick();
        end
`endif

        tick(); tick();
        chk("exp_q_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
